rom_dl_sequencer: RTL and testbench

//  Write-side producer for the ROMCL/ROMAD/ROMDT/ROMEN download bus consumed by the video ROMs
//  (sprite $10000, tile $20000-$2BFFF, CLUT $2C000). Accepts the host byte stream with valid/ready,

---
 rtl/rom_dl_sequencer.sv | 137 +++++++++++++
 tb/tb_rom_dl_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// Download-bus producer: buffers host bytes in a small FIFO and emits paced one-cycle
// ROMEN writes at sequential ROM addresses, with byte count, checksum and overrun tracking.
module rom_dl_sequencer #(
  parameter int          FIFO_AW  = 2,
  parameter int          GAP      = 1,
  parameter logic [24:0] END_ADDR = 25'h2C100
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DL_START,
  input  logic        DL_VALID,
  output logic        DL_READY,
  input  logic [7:0]  DL_DATA,
  input  logic        DL_LAST,
  output logic        ROMCL,
  output logic [24:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVERRUN,
  output logic [15:0] CHKSUM
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int GW    = (GAP < 1) ? 1 : $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [24:0]         acc_addr_reg, wr_addr_reg, romad_reg;
  logic [7:0]          romdt_reg;
  logic                romen_reg, overrun_reg;
  logic [15:0]         chksum_reg;
  logic [GW-1:0]       gap_reg;

  logic                fifo_empty, fifo_full, accept, in_range, push, pop;
  logic [7:0]          pop_data;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign DL_READY   = (state_reg == S_LOAD) && !fifo_full;
  assign accept     = DL_VALID && DL_READY && !DL_START;
  assign in_range   = (acc_addr_reg < END_ADDR);
  assign push       = accept && in_range;
  // An empty FIFO forwards the incoming byte straight to the write stage.
  assign pop        = !DL_START && (!fifo_empty || push) && (gap_reg == '0);
  assign pop_data   = fifo_empty ? DL_DATA : fifo_mem[rd_ptr_reg];

  always_comb begin
    state_next = state_reg;
    if (DL_START) begin
      state_next = S_LOAD;
    end else begin
      case (state_reg)
        S_LOAD:  if (accept && DL_LAST) state_next = S_DRAIN;
        S_DRAIN: if (fifo_empty && (gap_reg == '0) && !romen_reg) state_next = S_DONE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= DL_DATA;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      acc_addr_reg <= '0;
      wr_addr_reg  <= '0;
      romad_reg    <= '0;
      romdt_reg    <= '0;
      romen_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
      chksum_reg   <= '0;
      gap_reg      <= '0;
    end else if (DL_START) begin
      // Abort/restart: drop queued bytes and all per-image bookkeeping.
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      acc_addr_reg <= '0;
      wr_addr_reg  <= '0;
      romen_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
      chksum_reg   <= '0;
      gap_reg      <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      if (accept) begin
        if (in_range) acc_addr_reg <= acc_addr_reg + 25'd1;
        else          overrun_reg  <= 1'b1;
      end

      if (pop) begin
        romen_reg   <= 1'b1;
        romad_reg   <= wr_addr_reg;
        romdt_reg   <= pop_data;
        chksum_reg  <= chksum_reg + {8'd0, pop_data};
        wr_addr_reg <= wr_addr_reg + 25'd1;
        gap_reg     <= GW'(GAP);
      end else begin
        romen_reg <= 1'b0;
        if (gap_reg != '0) gap_reg <= gap_reg - GW'(1);
      end
    end
  end

  assign ROMCL   = CLK;
  assign ROMAD   = romad_reg;
  assign ROMDT   = romdt_reg;
  assign ROMEN   = romen_reg;
  assign BUSY    = (state_reg == S_LOAD) || (state_reg == S_DRAIN);
  assign DONE    = (state_reg == S_DONE);
  assign OVERRUN = overrun_reg;
  assign CHKSUM  = chksum_reg;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Bench for rom_dl_sequencer: directed and random download sessions checked against an
// image-level model (list of bytes to be written, running sum, occupancy and pacing rules).
module tb_rom_dl_sequencer;

  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 4;
  localparam int GAP     = 1;
  localparam int END     = 20;
  localparam int MINGAP  = (GAP > 0) ? GAP : 1;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;

  logic        CLK = 1'b0;
  logic        RESET_N, DL_START, DL_VALID, DL_LAST;
  logic [7:0]  DL_DATA;
  logic        DL_READY, ROMCL, ROMEN, BUSY, DONE, OVERRUN;
  logic [24:0] ROMAD;
  logic [7:0]  ROMDT;
  logic [15:0] CHKSUM;

  rom_dl_sequencer #(.FIFO_AW(FIFO_AW), .GAP(GAP), .END_ADDR(25'(END))) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DL_START(DL_START), .DL_VALID(DL_VALID),
    .DL_READY(DL_READY), .DL_DATA(DL_DATA), .DL_LAST(DL_LAST), .ROMCL(ROMCL),
    .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN), .BUSY(BUSY), .DONE(DONE),
    .OVERRUN(OVERRUN), .CHKSUM(CHKSUM)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Model: bytes destined for the ROM, how many have appeared on ROMEN, and pacing state.
  int stored[$];
  int n_written;
  int exp_sum;
  bit exp_ovr;
  int phase;
  int since;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int ph);
    stored.delete();
    n_written = 0;
    exp_sum   = 0;
    exp_ovr   = 1'b0;
    phase     = ph;
    since     = 1000;
  endtask

  // One clock: drive inputs, apply handshake to the model, advance, then check outputs.
  task automatic tick(input logic st, input logic v, input logic [7:0] d, input logic l,
                      output bit acc);
    bit exp_en;
    int nphase;
    DL_START = st; DL_VALID = v; DL_DATA = d; DL_LAST = l;
    chk("ready", 32'(DL_READY),
        32'((phase == P_LOAD) && ((stored.size() - n_written) < DEPTH)));
    acc    = v && DL_READY && !st;
    nphase = phase;
    exp_en = 1'b0;
    if (st) begin
      model_clear(P_LOAD);
      nphase = P_LOAD;
    end else begin
      if (acc) begin
        if (stored.size() < END) stored.push_back(int'(d));
        else                     exp_ovr = 1'b1;
        if (l) nphase = P_DRAIN;
      end
      if (phase == P_DRAIN && stored.size() == n_written && since >= MINGAP)
        nphase = P_DONE;
      exp_en = (stored.size() > n_written) && (since >= GAP);
    end
    @(posedge CLK); #1;
    phase = nphase;
    if (since < 1000) since++;
    chk("romen", 32'(ROMEN), 32'(exp_en));
    if (ROMEN === 1'b1) begin
      chk("romad", 32'(ROMAD), 32'(n_written));
      if (n_written < stored.size()) begin
        chk("romdt", 32'(ROMDT), 32'(stored[n_written]));
        exp_sum = (exp_sum + stored[n_written]) & 16'hFFFF;
      end
      n_written++;
      since = 0;
    end
    chk("chksum", 32'(CHKSUM), 32'(exp_sum));
    chk("overrun", 32'(OVERRUN), 32'(exp_ovr));
    chk("done", 32'(DONE), 32'(phase == P_DONE));
    chk("busy", 32'(BUSY), 32'((phase == P_LOAD) || (phase == P_DRAIN)));
    DL_START = 1'b0; DL_VALID = 1'b0; DL_LAST = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit l, input int pct);
    bit acc;
    int tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 100) begin
      tick(1'b0, ($urandom_range(99) < pct), d, l, acc);
      tries++;
    end
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    int t;
    t = 0;
    while (DONE !== 1'b1 && t < 200) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0, acc);
      t++;
    end
    chk("done_reached", 32'(DONE), 32'd1);
    chk("all_written", 32'(n_written), 32'(stored.size()));
  endtask

  task automatic start();
    bit acc;
    tick(1'b1, 1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic session(input int len, input int pct, input int abort_at);
    bit acc;
    start();
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) tick(1'b1, 1'($urandom_range(1)), 8'($urandom), 1'b0, acc);
      send(8'($urandom), (i == len - 1), pct);
    end
    drain();
  endtask

  task automatic async_reset();
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_romen", 32'(ROMEN), 32'd0);
    chk("rst_romad", 32'(ROMAD), 32'd0);
    chk("rst_romdt", 32'(ROMDT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_overrun", 32'(OVERRUN), 32'd0);
    chk("rst_chksum", 32'(CHKSUM), 32'd0);
    chk("rst_ready", 32'(DL_READY), 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    model_clear(P_IDLE);
  endtask

  initial begin
    bit acc;
    RESET_N = 1'b0; DL_START = 1'b0; DL_VALID = 1'b0; DL_DATA = 8'h00; DL_LAST = 1'b0;
    model_clear(P_IDLE);
    repeat (2) @(posedge CLK);
    #1;
    chk("init_romen", 32'(ROMEN), 32'd0);
    chk("init_done", 32'(DONE), 32'd0);
    chk("init_chksum", 32'(CHKSUM), 32'd0);
    RESET_N = 1'b1;

    // Three-byte image, bytes written two cycles apart.
    start();
    send(8'h11, 1'b0, 100);
    send(8'h22, 1'b0, 100);
    send(8'h33, 1'b1, 100);
    drain();
    chk("img3_chksum", 32'(CHKSUM), 32'h0066);
    chk("img3_last_addr", 32'(ROMAD), 32'd2);

    // Continuous VALID: FIFO fills, READY throttles, nothing lost.
    start();
    for (int i = 0; i < 12; i++) send(8'(i + 8'h40), (i == 11), 100);
    drain();

    // Overlong image: bytes past END discarded, OVERRUN sticky.
    start();
    for (int i = 1; i <= 25; i++) send(8'(i), (i == 25), 100);
    drain();
    chk("ovr_flag", 32'(OVERRUN), 32'd1);
    chk("ovr_chksum", 32'(CHKSUM), 32'h00D2);
    chk("ovr_last_addr", 32'(ROMAD), 32'(END - 1));

    // Abort after 5 bytes, with a byte in flight on the START cycle.
    start();
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b0, 100);
    tick(1'b1, 1'b1, 8'hEE, 1'b0, acc);
    chk("abort_no_accept", 32'(acc), 32'd0);
    send(8'h5A, 1'b1, 100);
    drain();
    chk("abort_addr", 32'(ROMAD), 32'd0);
    chk("abort_chksum", 32'(CHKSUM), 32'h005A);

    // Reset while draining, then a one-byte image.
    start();
    for (int i = 0; i < 8; i++) send(8'(8'hC0 + i), (i == 7), 100);
    tick(1'b0, 1'b0, 8'h00, 1'b0, acc);
    async_reset();
    start();
    send(8'h77, 1'b1, 100);
    drain();
    chk("post_rst_addr", 32'(ROMAD), 32'd0);
    chk("post_rst_chksum", 32'(CHKSUM), 32'h0077);

    // Random sessions with random pacing, lengths crossing END, occasional abort.
    for (int s = 0; s < 12; s++) begin
      int len, pct, ab;
      len = $urandom_range(28, 1);
      pct = $urandom_range(100, 30);
      ab  = ($urandom_range(3) == 0) ? $urandom_range(len - 1) : -1;
      session(len, pct, ab);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
